// File: rtl/cache_port_arbiter.sv
// Two-requester round-robin arbiter sharing the cache's single-beat AXI-style
// host port. One whole transaction (address + data beat) per grant; addresses
// are re-issued downstream from a register, data beats pass through combinationally.
module cache_port_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  // requester side
  input  logic [1:0]              s_axi_ARVALID,
  output logic [1:0]              s_axi_ARREADY,
  input  logic [2*ADDR_WIDTH-1:0] s_axi_ARADDR,
  output logic [1:0]              s_axi_RVALID,
  input  logic [1:0]              s_axi_RREADY,
  output logic [2*DATA_WIDTH-1:0] s_axi_RDATA,
  input  logic [1:0]              s_axi_AWVALID,
  output logic [1:0]              s_axi_AWREADY,
  input  logic [2*ADDR_WIDTH-1:0] s_axi_AWADDR,
  input  logic [1:0]              s_axi_WVALID,
  output logic [1:0]              s_axi_WREADY,
  input  logic [2*DATA_WIDTH-1:0] s_axi_WDATA,
  // cache side
  output logic                    m_axi_ARVALID,
  output logic [ADDR_WIDTH-1:0]   m_axi_ARADDR,
  input  logic                    m_axi_ARREADY,
  input  logic                    m_axi_RVALID,
  input  logic [DATA_WIDTH-1:0]   m_axi_RDATA,
  output logic                    m_axi_RREADY,
  output logic                    m_axi_AWVALID,
  output logic [ADDR_WIDTH-1:0]   m_axi_AWADDR,
  input  logic                    m_axi_AWREADY,
  output logic                    m_axi_WVALID,
  output logic [DATA_WIDTH-1:0]   m_axi_WDATA,
  input  logic                    m_axi_WREADY,
  // status
  output logic [1:0]              grant,
  output logic                    busy
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_ADDR = 3'd3,
    WR_DATA = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic                    last_grant_q, last_grant_d;
  logic                    gid_q, gid_d;
  logic                    ar_valid_d, aw_valid_d;
  logic [ADDR_WIDTH-1:0]   ar_addr_d, aw_addr_d;

  logic [1:0]              eligible;
  logic                    win;
  logic [ADDR_WIDTH-1:0]   win_araddr, win_awaddr;
  logic [DATA_WIDTH-1:0]   gnt_wdata;

  // Round-robin pick: on a tie the requester that did not go last wins
  assign eligible   = s_axi_ARVALID | s_axi_AWVALID;
  assign win        = (eligible == 2'b11) ? ~last_grant_q : eligible[1];
  assign win_araddr = win   ? s_axi_ARADDR[2*ADDR_WIDTH-1:ADDR_WIDTH] : s_axi_ARADDR[ADDR_WIDTH-1:0];
  assign win_awaddr = win   ? s_axi_AWADDR[2*ADDR_WIDTH-1:ADDR_WIDTH] : s_axi_AWADDR[ADDR_WIDTH-1:0];
  assign gnt_wdata  = gid_q ? s_axi_WDATA[2*DATA_WIDTH-1:DATA_WIDTH]  : s_axi_WDATA[DATA_WIDTH-1:0];

  // Next-state, address capture and combinational handshake routing
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    gid_d         = gid_q;
    ar_valid_d    = m_axi_ARVALID;
    ar_addr_d     = m_axi_ARADDR;
    aw_valid_d    = m_axi_AWVALID;
    aw_addr_d     = m_axi_AWADDR;
    s_axi_ARREADY = 2'b00;
    s_axi_AWREADY = 2'b00;
    s_axi_WREADY  = 2'b00;
    s_axi_RVALID  = 2'b00;
    s_axi_RDATA   = '0;
    m_axi_RREADY  = 1'b0;
    m_axi_WVALID  = 1'b0;
    m_axi_WDATA   = '0;
    if (reset_n) begin
      s_axi_RDATA = {2{m_axi_RDATA}};
      case (state_q)
        IDLE: begin
          if (eligible != 2'b00) begin
            gid_d = win;
            // read beats write within the winning requester
            if (s_axi_ARVALID[win]) begin
              s_axi_ARREADY[win] = 1'b1;
              ar_addr_d          = win_araddr;
              ar_valid_d         = 1'b1;
              state_d            = RD_ADDR;
            end else begin
              s_axi_AWREADY[win] = 1'b1;
              aw_addr_d          = win_awaddr;
              aw_valid_d         = 1'b1;
              state_d            = WR_ADDR;
            end
          end
        end
        RD_ADDR: begin
          if (m_axi_ARREADY) begin
            ar_valid_d = 1'b0;
            state_d    = RD_DATA;
          end
        end
        RD_DATA: begin
          s_axi_RVALID[gid_q] = m_axi_RVALID;
          m_axi_RREADY        = s_axi_RREADY[gid_q];
          if (m_axi_RVALID && s_axi_RREADY[gid_q]) begin
            last_grant_d = gid_q;
            state_d      = IDLE;
          end
        end
        WR_ADDR: begin
          if (m_axi_AWREADY) begin
            aw_valid_d = 1'b0;
            state_d    = WR_DATA;
          end
        end
        WR_DATA: begin
          m_axi_WVALID        = s_axi_WVALID[gid_q];
          m_axi_WDATA         = gnt_wdata;
          s_axi_WREADY[gid_q] = m_axi_WREADY;
          if (m_axi_WREADY && s_axi_WVALID[gid_q]) begin
            last_grant_d = gid_q;
            state_d      = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      last_grant_q  <= 1'b1;
      gid_q         <= 1'b0;
      m_axi_ARVALID <= 1'b0;
      m_axi_ARADDR  <= '0;
      m_axi_AWVALID <= 1'b0;
      m_axi_AWADDR  <= '0;
      grant         <= 2'b00;
      busy          <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      gid_q         <= gid_d;
      m_axi_ARVALID <= ar_valid_d;
      m_axi_ARADDR  <= ar_addr_d;
      m_axi_AWVALID <= aw_valid_d;
      m_axi_AWADDR  <= aw_addr_d;
      grant         <= (state_d == IDLE) ? 2'b00 : (gid_d ? 2'b10 : 2'b01);
      busy          <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Directed bench for cache_port_arbiter: host agents, a simple cache model and
// a scoreboard of expected downstream addresses / data beats in service order.
module tb_cache_port_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 8;

  logic            clk;
  logic            reset_n;
  logic [1:0]      s_axi_ARVALID, s_axi_ARREADY, s_axi_RVALID, s_axi_RREADY;
  logic [1:0]      s_axi_AWVALID, s_axi_AWREADY, s_axi_WVALID, s_axi_WREADY;
  logic [2*AW-1:0] s_axi_ARADDR, s_axi_AWADDR;
  logic [2*DW-1:0] s_axi_RDATA, s_axi_WDATA;
  logic            m_axi_ARVALID, m_axi_ARREADY, m_axi_RVALID, m_axi_RREADY;
  logic            m_axi_AWVALID, m_axi_AWREADY, m_axi_WVALID, m_axi_WREADY;
  logic [AW-1:0]   m_axi_ARADDR, m_axi_AWADDR;
  logic [DW-1:0]   m_axi_RDATA, m_axi_WDATA;
  logic [1:0]      grant;
  logic            busy;

  cache_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset_n(reset_n),
    .s_axi_ARVALID(s_axi_ARVALID), .s_axi_ARREADY(s_axi_ARREADY), .s_axi_ARADDR(s_axi_ARADDR),
    .s_axi_RVALID(s_axi_RVALID), .s_axi_RREADY(s_axi_RREADY), .s_axi_RDATA(s_axi_RDATA),
    .s_axi_AWVALID(s_axi_AWVALID), .s_axi_AWREADY(s_axi_AWREADY), .s_axi_AWADDR(s_axi_AWADDR),
    .s_axi_WVALID(s_axi_WVALID), .s_axi_WREADY(s_axi_WREADY), .s_axi_WDATA(s_axi_WDATA),
    .m_axi_ARVALID(m_axi_ARVALID), .m_axi_ARADDR(m_axi_ARADDR), .m_axi_ARREADY(m_axi_ARREADY),
    .m_axi_RVALID(m_axi_RVALID), .m_axi_RDATA(m_axi_RDATA), .m_axi_RREADY(m_axi_RREADY),
    .m_axi_AWVALID(m_axi_AWVALID), .m_axi_AWADDR(m_axi_AWADDR), .m_axi_AWREADY(m_axi_AWREADY),
    .m_axi_WVALID(m_axi_WVALID), .m_axi_WDATA(m_axi_WDATA), .m_axi_WREADY(m_axi_WREADY),
    .grant(grant), .busy(busy)
  );

  typedef struct packed {
    logic          rd;
    logic          wr;
    logic [AW-1:0] raddr;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
  } op_t;

  typedef struct packed {
    logic [1:0]    gnt;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  op_t  q0[$];
  op_t  q1[$];
  exp_t exp_ar[$];
  exp_t exp_r[$];
  exp_t exp_aw[$];
  exp_t exp_w[$];

  int checks;
  int errors;
  int gc0;
  int gc1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Cache read data is a fixed function of the address
  function automatic logic [DW-1:0] rd_data(input logic [AW-1:0] a);
    return a[7:0] ^ 8'h91;
  endfunction

  function automatic logic [1:0] onehot(input int i);
    return (i == 0) ? 2'b01 : 2'b10;
  endfunction

  // Host agents: hold VALIDs until their handshake, then take the next queued op
  initial begin
    s_axi_ARVALID = 2'b00; s_axi_AWVALID = 2'b00; s_axi_WVALID = 2'b00;
    s_axi_ARADDR  = '0;    s_axi_AWADDR  = '0;    s_axi_WDATA  = '0;
    forever begin
      logic [1:0] arf, awf, wf;
      op_t        op;
      logic       got;
      @(negedge clk);
      arf = s_axi_ARVALID & s_axi_ARREADY;
      awf = s_axi_AWVALID & s_axi_AWREADY;
      wf  = s_axi_WVALID  & s_axi_WREADY;
      @(posedge clk); #1;
      s_axi_ARVALID = s_axi_ARVALID & ~arf;
      s_axi_AWVALID = s_axi_AWVALID & ~awf;
      s_axi_WVALID  = s_axi_WVALID  & ~wf;
      for (int i = 0; i < 2; i++) begin
        if (!s_axi_ARVALID[i] && !s_axi_AWVALID[i] && !s_axi_WVALID[i]) begin
          got = 1'b0;
          op  = '0;
          if (i == 0 && q0.size() != 0) begin op = q0.pop_front(); got = 1'b1; end
          if (i == 1 && q1.size() != 0) begin op = q1.pop_front(); got = 1'b1; end
          if (got) begin
            s_axi_ARADDR[i*AW +: AW] = op.raddr;
            s_axi_AWADDR[i*AW +: AW] = op.waddr;
            s_axi_WDATA[i*DW +: DW]  = op.wdata;
            s_axi_ARVALID[i]         = op.rd;
            s_axi_AWVALID[i]         = op.wr;
            s_axi_WVALID[i]          = op.wr;
          end
        end
      end
    end
  end

  // Cache model and scoreboard monitor
  initial begin
    m_axi_RVALID = 1'b0;
    m_axi_RDATA  = '0;
    forever begin
      logic          ar_fire, r_fire, w_fire, rst_seen;
      logic [AW-1:0] ar_addr;
      exp_t          e;
      ar_fire = 1'b0; r_fire = 1'b0; w_fire = 1'b0; ar_addr = '0;
      @(negedge clk);
      rst_seen = !reset_n;
      if (reset_n) begin
        if (busy) begin
          chk("up_ready_quiet", 64'({s_axi_ARREADY, s_axi_AWREADY}), 64'(0));
          chk("nongrant_quiet", 64'((s_axi_RVALID | s_axi_WREADY) & ~grant), 64'(0));
        end
        if (m_axi_ARVALID && m_axi_ARREADY) begin
          ar_fire = 1'b1;
          ar_addr = m_axi_ARADDR;
          if (exp_ar.size() == 0) chk("ar_unexpected", 64'(1), 64'(0));
          else begin
            e = exp_ar.pop_front();
            chk("ar_addr", 64'(m_axi_ARADDR), 64'(e.addr));
            chk("ar_grant", 64'(grant), 64'(e.gnt));
          end
        end
        if (m_axi_RVALID && m_axi_RREADY) begin
          r_fire = 1'b1;
          if (grant == 2'b01) gc0++;
          if (grant == 2'b10) gc1++;
          if (exp_r.size() == 0) chk("r_unexpected", 64'(1), 64'(0));
          else begin
            e = exp_r.pop_front();
            chk("r_valid", 64'(s_axi_RVALID), 64'(e.gnt));
            chk("r_data", 64'(s_axi_RDATA), 64'({e.data, e.data}));
            chk("r_grant", 64'(grant), 64'(e.gnt));
          end
        end
        if (m_axi_AWVALID && m_axi_AWREADY) begin
          if (exp_aw.size() == 0) chk("aw_unexpected", 64'(1), 64'(0));
          else begin
            e = exp_aw.pop_front();
            chk("aw_addr", 64'(m_axi_AWADDR), 64'(e.addr));
            chk("aw_grant", 64'(grant), 64'(e.gnt));
          end
        end
        if (m_axi_WVALID && m_axi_WREADY) begin
          w_fire = 1'b1;
          if (exp_w.size() == 0) chk("w_unexpected", 64'(1), 64'(0));
          else begin
            e = exp_w.pop_front();
            chk("w_data", 64'(m_axi_WDATA), 64'(e.data));
            chk("w_ready", 64'(s_axi_WREADY), 64'(e.gnt));
            chk("w_grant", 64'(grant), 64'(e.gnt));
          end
        end
      end
      @(posedge clk); #1;
      if (rst_seen) begin
        m_axi_RVALID = 1'b0;
        m_axi_RDATA  = '0;
      end else begin
        if (ar_fire) begin
          m_axi_RVALID = 1'b1;
          m_axi_RDATA  = rd_data(ar_addr);
        end
        if (r_fire) begin
          m_axi_RVALID = 1'b0;
          m_axi_RDATA  = '0;
        end
        if (r_fire || w_fire) chk("idle_after_data", 64'(busy), 64'(0));
      end
    end
  end

  task automatic rd(input int i, input logic [AW-1:0] a, input bit want_r);
    op_t  op;
    exp_t e;
    op = '{rd: 1'b1, wr: 1'b0, raddr: a, waddr: '0, wdata: '0};
    if (i == 0) q0.push_back(op); else q1.push_back(op);
    e = '{gnt: onehot(i), addr: a, data: rd_data(a)};
    exp_ar.push_back(e);
    if (want_r) exp_r.push_back(e);
  endtask

  task automatic rdwr(input int i, input logic [AW-1:0] ra, input logic [AW-1:0] wa,
                      input logic [DW-1:0] wd);
    op_t  op;
    exp_t e;
    op = '{rd: 1'b1, wr: 1'b1, raddr: ra, waddr: wa, wdata: wd};
    if (i == 0) q0.push_back(op); else q1.push_back(op);
    e = '{gnt: onehot(i), addr: ra, data: rd_data(ra)};
    exp_ar.push_back(e);
    exp_r.push_back(e);
    e = '{gnt: onehot(i), addr: wa, data: wd};
    exp_aw.push_back(e);
    exp_w.push_back(e);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while ((exp_ar.size() + exp_r.size() + exp_aw.size() + exp_w.size() + q0.size() + q1.size()) != 0
           || busy) begin
      @(negedge clk);
      n++;
      if (n > 500) break;
    end
    chk({tag, "_timeout"}, 64'(n > 500), 64'(0));
    if (n > 500) begin
      exp_ar.delete(); exp_r.delete(); exp_aw.delete(); exp_w.delete();
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_m_valids"}, 64'({m_axi_ARVALID, m_axi_AWVALID, m_axi_WVALID, m_axi_RREADY}), 64'(0));
    chk({tag, "_m_araddr"}, 64'(m_axi_ARADDR), 64'(0));
    chk({tag, "_m_awaddr"}, 64'(m_axi_AWADDR), 64'(0));
    chk({tag, "_m_wdata"},  64'(m_axi_WDATA), 64'(0));
    chk({tag, "_grant_busy"}, 64'({grant, busy}), 64'(0));
    chk({tag, "_s_hs"}, 64'({s_axi_ARREADY, s_axi_AWREADY, s_axi_WREADY, s_axi_RVALID}), 64'(0));
    chk({tag, "_s_rdata"}, 64'(s_axi_RDATA), 64'(0));
  endtask

  // Global time limit
  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    checks = 0; errors = 0; gc0 = 0; gc1 = 0;
    reset_n       = 1'b0;
    s_axi_RREADY  = 2'b11;
    m_axi_ARREADY = 1'b1;
    m_axi_AWREADY = 1'b1;
    m_axi_WREADY  = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check_all_zero("reset");

    // lone read from requester 0
    rd(0, 32'h0000_1234, 1'b1);
    wait_done("t1_read");

    // both requesters from reset: 0 then 1
    do_reset();
    rd(0, 32'h0000_0100, 1'b1);
    rd(1, 32'h0000_0200, 1'b1);
    wait_done("t2_both");

    // requester 1 read+write together: read first
    rdwr(1, 32'h0000_0300, 32'h0000_0400, 8'h3C);
    wait_done("t3_rdwr");

    // downstream ARREADY stalled for 3 cycles
    m_axi_ARREADY = 1'b0;
    rd(0, 32'h0000_1ABC, 1'b1);
    n = 0;
    @(negedge clk);
    while (!m_axi_ARVALID && n < 50) begin @(negedge clk); n++; end
    chk("t4_arvalid_seen", 64'(m_axi_ARVALID), 64'(1));
    for (int k = 0; k < 4; k++) begin
      chk("t4_stall_valid", 64'(m_axi_ARVALID), 64'(1));
      chk("t4_stall_addr", 64'(m_axi_ARADDR), 64'(32'h0000_1ABC));
      chk("t4_stall_busy", 64'(busy), 64'(1));
      @(posedge clk); #1;
      if (k == 2) m_axi_ARREADY = 1'b1;
      @(negedge clk);
    end
    wait_done("t4_stall");

    // continuous streaming from both: strict alternation
    do_reset();
    gc0 = 0; gc1 = 0;
    for (int k = 0; k < 4; k++) begin
      rd(0, 32'h0000_2000 + 32'(k * 16), 1'b1);
      rd(1, 32'h0000_3000 + 32'(k * 16 + 3), 1'b1);
    end
    wait_done("t5_stream");
    chk("t5_count0", 64'(gc0), 64'(4));
    chk("t5_count1", 64'(gc1), 64'(4));

    // reset during RD_DATA
    s_axi_RREADY = 2'b00;
    rd(0, 32'h0000_0055, 1'b0);
    n = 0;
    @(negedge clk);
    while (!s_axi_RVALID[0] && n < 50) begin @(negedge clk); n++; end
    chk("t6_in_rd_data", 64'(s_axi_RVALID), 64'(2'b01));
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(negedge clk);
    chk("t6_rst_rvalid", 64'(s_axi_RVALID), 64'(0));
    chk("t6_rst_rready", 64'(m_axi_RREADY), 64'(0));
    @(posedge clk); #1;
    reset_n      = 1'b1;
    s_axi_RREADY = 2'b11;
    @(negedge clk);
    check_all_zero("t6_after_rst");
    rd(0, 32'h0000_0600, 1'b1);
    rd(1, 32'h0000_0700, 1'b1);
    wait_done("t6_regrant");

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_port_arbiter.md
# cache_port_arbiter

Two-requester round-robin arbiter that shares the cache controller's single host-side AXI-style port (AR/R/AW/W, single-beat) between two hosts. It sits directly upstream of the cache controller. It accepts one whole transaction at a time and holds the grant until that transaction's data beat completes. It forwards the address downstream through a register and routes the data phase combinationally.

## Interface
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 8, data beat width
- clk  in  1  clock, all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- s_axi_ARVALID / s_axi_ARREADY  in/out  2  per-requester read address handshake (bit i = requester i)
- s_axi_ARADDR  in  2*ADDR_WIDTH  requester i address at [i*ADDR_WIDTH +: ADDR_WIDTH]
- s_axi_RVALID / s_axi_RREADY  out/in  2  per-requester read data handshake
- s_axi_RDATA  out  2*DATA_WIDTH  read data, both slices driven with m_axi_RDATA
- s_axi_AWVALID / s_axi_AWREADY  in/out  2  per-requester write address handshake
- s_axi_AWADDR  in  2*ADDR_WIDTH  write addresses, packed as ARADDR
- s_axi_WVALID / s_axi_WREADY  in/out  2  per-requester write data handshake
- s_axi_WDATA  in  2*DATA_WIDTH  write data, packed
- m_axi_ARVALID, m_axi_ARADDR / m_axi_ARREADY  out / in  1, ADDR_WIDTH / 1  downstream read address channel to the cache
- m_axi_RVALID, m_axi_RDATA / m_axi_RREADY  in / out  1, DATA_WIDTH / 1  downstream read data channel
- m_axi_AWVALID, m_axi_AWADDR / m_axi_AWREADY  out / in  1, ADDR_WIDTH / 1  downstream write address channel
- m_axi_WVALID, m_axi_WDATA / m_axi_WREADY  out / in  1, DATA_WIDTH / 1  downstream write data channel
- grant  out  2  one-hot owner of the current transaction; 0 when IDLE
- busy  out  1  high in any state other than IDLE

## Operation
- The FSM has five states: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA.
- Requester i is eligible when s_axi_ARVALID[i] or s_axi_AWVALID[i] is high.
- **Selection in IDLE:**
  - If both requesters are eligible, the winner is the one other than last_grant.
  - If only one is eligible, that requester wins.
  - On reset, last_grant = 1, so requester 0 wins first.
- **Operation choice in IDLE:** within the winner, read has priority over write.
- **IDLE address acceptance:**
  - s_axi_ARREADY[w] = 1 (or s_axi_AWREADY[w] = 1 for a write) is driven combinationally for the winner only.
  - On that handshake, the arbiter latches the address, grant_id and op, then moves to RD_ADDR or WR_ADDR.
- **RD_ADDR / WR_ADDR:**
  - Registered m_axi_ARVALID (or m_axi_AWVALID) is high, carrying the latched address.
  - VALID holds until m_axi_*READY is sampled high.
  - On that handshake, VALID clears and the FSM moves to RD_DATA / WR_DATA.
- **RD_DATA:**
  - s_axi_RVALID[g] = m_axi_RVALID.
  - m_axi_RREADY = s_axi_RREADY[g].
  - On the R handshake: go to IDLE and set last_grant = g.
- **WR_DATA:**
  - m_axi_WVALID = s_axi_WVALID[g].
  - m_axi_WDATA = s_axi_WDATA slice g.
  - s_axi_WREADY[g] = m_axi_WREADY.
  - On the W handshake: go to IDLE and set last_grant = g.
- **Non-granted requester:** all of its READY/VALID outputs stay 0 in every state.
- **Quiet states:**
  - The downstream channels not used by the current state keep VALID/READY at 0.
  - All upstream READYs are 0 outside IDLE.
- Requester VALIDs are not checked for stability; a requester that drops VALID before its grant simply loses eligibility.
- **Reset (reset_n low at a rising edge):**
  - The FSM returns to IDLE.
  - All registered outputs clear, last_grant = 1, and grant/busy = 0.
  - Combinational READY/VALID outputs are forced to 0 while reset_n is low.
  - An in-flight transaction is abandoned; the cache is reset by the same reset_n.

## Timing
- **Reset values:** every output is 0, including ARADDR/AWADDR/WDATA/RDATA registers and grant/busy.
- **Address path:**
  - Upstream address handshake at cycle T.
  - m_axi_*VALID is high from T+1.
  - Downstream address handshake at T+k (k ≥ 1) puts the FSM in the data state at T+k+1.
- **Data path:**
  - Zero-cycle combinational pass-through.
  - The data handshake at cycle D returns the FSM to IDLE at D+1.
  - A new grant is possible at D+1.
- **Minimum occupancy:** 3 cycles per transaction, when downstream READY is always high.
- **Simultaneous events:**
  - AR and AW from the same winner in the same cycle: the read goes first, and AW stays pending. After the read completes, last_grant = that requester, so the other requester wins if it is eligible.
  - Both requesters assert at reset: requester 0, then requester 1, alternating while both keep requesting.

## Test plan
- Requester 0 reads 0x0000_1234 alone, with m_axi_ARREADY = 1 and m_axi_RVALID returning 0xA5 → s_axi_RVALID[0] rises with RDATA 0xA5, grant = 01, back in IDLE 1 cycle after the R handshake.
- Both requesters assert ARVALID from reset with addresses 0x100 and 0x200 → downstream ARADDR sequence is 0x100 then 0x200, grant goes 01 then 10, and s_axi_ARREADY[1] stays 0 during the first transaction.
- Requester 1 asserts ARVALID and AWVALID together while requester 0 is idle → read first, then write (WDATA 0x3C reaches m_axi_WDATA), with grant = 10 for both.
- m_axi_ARREADY is held low for 3 cycles → m_axi_ARVALID stays high and ARADDR stays stable for 4 cycles, and busy = 1 throughout.
- Both requesters stream reads continuously for 8 transactions → grants strictly alternate, 4 each.
- reset_n is dropped for 1 cycle during RD_DATA → all outputs are 0 on the next cycle, and the next simultaneous request grants requester 0.
